// File: rtl/reflet_ram_seq_pkg.sv
// Shared types and sizing helpers for the word-to-byte RAM sequencer.
package reflet_ram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int nbytes(input int ws);
    return ws / 8;
  endfunction

  // Byte-lane index width; a 1-byte word still needs a 1-bit counter.
  function automatic int idx_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/reflet_ram_seq_if.sv
// CPU-side word access bus of the RAM sequencer.
interface reflet_ram_seq_if #(
  parameter int WS = 16,
  parameter int AS = 16
);
  logic          req;
  logic          write_en;
  logic [AS-1:0] addr;
  logic [WS-1:0] data_in;
  logic [WS-1:0] data_out;
  logic          ready;
  logic          error;

  modport master(output req, write_en, addr, data_in,
                 input  data_out, ready, error);
  modport slave (input  req, write_en, addr, data_in,
                 output data_out, ready, error);
endinterface

// File: rtl/reflet_byte_lane.sv
// Replaces byte i_idx of i_word with i_byte when i_en is set.
import reflet_ram_seq_pkg::*;

module reflet_byte_lane #(
  parameter int WS   = 16,
  parameter int IDXW = 1
) (
  input  logic [WS-1:0]   i_word,
  input  logic [IDXW-1:0] i_idx,
  input  logic [7:0]      i_byte,
  input  logic            i_en,
  output logic [WS-1:0]   o_word
);
  localparam int NB = nbytes(WS);

  for (genvar j = 0; j < NB; j++) begin : g_lane
    assign o_word[8*j +: 8] = (i_en && (i_idx == IDXW'(j))) ? i_byte : i_word[8*j +: 8];
  end
endmodule

// File: rtl/reflet_ram_seq.sv
// Splits a CPU word load/store into little-endian byte accesses on an 8-bit RAM.
// Optional REFLET_RAM_SEQ_ALIGN_CHECK_EN rejects misaligned requests with error.
import reflet_ram_seq_pkg::*;

module reflet_ram_seq #(
  parameter int wordsize = 16,
  parameter int addrSize = 16
) (
  input  logic                clk,
  input  logic                reset,
  reflet_ram_seq_if.slave     cpu,
  output logic                o_ram_enable,
  output logic [addrSize-1:0] o_ram_addr,
  output logic [7:0]          o_ram_data_in,
  output logic                o_ram_write_en,
  input  logic [7:0]          i_ram_data_out
);
  localparam int NB   = nbytes(wordsize);
  localparam int IDXW = idx_w(NB);

  state_t                r_state, w_next_state;
  logic [IDXW-1:0]       r_k;
  logic [addrSize-1:0]   r_addr;
  logic [wordsize-1:0]   r_wdata;
  logic                  r_we;
  logic                  r_err;
  logic                  r_cap_vld;
  logic [IDXW-1:0]       r_cap_idx;
  logic [wordsize-1:0]   r_data;
  logic [wordsize-1:0]   w_data_next;
  logic                  w_last;
  logic                  w_misalign;

  assign w_last = (r_k == IDXW'(NB - 1));

`ifdef REFLET_RAM_SEQ_ALIGN_CHECK_EN
  assign w_misalign = ((cpu.addr % addrSize'(NB)) != '0);
`else
  assign w_misalign = 1'b0;
`endif

  // Read data arrives one cycle after its address; r_cap_* marks that cycle.
  reflet_byte_lane #(.WS(wordsize), .IDXW(IDXW)) u_lane (
    .i_word (r_data),
    .i_idx  (r_cap_idx),
    .i_byte (i_ram_data_out),
    .i_en   (r_cap_vld),
    .o_word (w_data_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:        if (cpu.req) w_next_state = w_misalign ? DONE : (cpu.write_en ? WRITE : READ);
      WRITE, READ: if (w_last)  w_next_state = DONE;
      DONE:        w_next_state = IDLE;
      default:     w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k       <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_data    <= '0;
    end else begin
      r_cap_vld <= (r_state == READ);
      r_cap_idx <= r_k;
      r_data    <= w_data_next;
      case (r_state)
        IDLE: if (cpu.req) begin
          r_addr  <= cpu.addr;
          r_we    <= cpu.write_en;
          r_wdata <= cpu.data_in;
          r_err   <= w_misalign;
          r_k     <= '0;
        end
        WRITE, READ: if (!w_last) r_k <= r_k + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_ram_enable   = 1'b0;
    o_ram_write_en = 1'b0;
    o_ram_addr     = '0;
    o_ram_data_in  = 8'h00;
    case (r_state)
      WRITE: begin
        o_ram_enable   = 1'b1;
        o_ram_write_en = r_we;
        o_ram_addr     = r_addr + addrSize'(r_k);
        o_ram_data_in  = r_wdata[{r_k, 3'b000} +: 8];
      end
      READ: begin
        o_ram_enable = 1'b1;
        o_ram_addr   = r_addr + addrSize'(r_k);
      end
      DONE: if (r_cap_vld) begin
        // Keep the RAM enabled so its gated output still shows the last byte.
        o_ram_enable = 1'b1;
        o_ram_addr   = r_addr + addrSize'(r_k);
      end
      default: ;
    endcase
  end

  assign cpu.ready    = (r_state == DONE);
  assign cpu.error    = (r_state == DONE) && r_err;
  assign cpu.data_out = ((r_state == DONE) && r_cap_vld) ? w_data_next : r_data;

endmodule
